store_buf_m: RTL and testbench

//   Posted-store FIFO in the M stage, directly upstream of the data memory. Stores

---
 rtl/store_buf_m.sv | 125 ++++++++++++
 tb/tb_store_buf_m.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/store_buf_m.sv
// Posted-store FIFO feeding the data memory port; muxes queued store writes and load accesses.
// Optional macro STBUF_BYPASS_EN lets a store write memory directly when the buffer is empty and no load is present.
module store_buf_m #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             St_valid,
  input  logic [31:0]      St_addr,
  input  logic [31:0]      St_data,
  input  logic [2:0]       St_type,
  input  logic [31:0]      St_instr,
  input  logic             Ld_valid,
  input  logic [31:0]      Ld_addr,
  input  logic [2:0]       Ld_type,
  input  logic [31:0]      Ld_wd,
  output logic             Stall,
  output logic             DM_WE,
  output logic [31:0]      DM_Addr,
  output logic [31:0]      DM_WD,
  output logic [2:0]       DM_LStype,
  output logic [31:0]      DM_Instr,
  output logic [PTR_W:0]   Count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [31:0] addr_q  [DEPTH];
  logic [31:0] data_q  [DEPTH];
  logic [2:0]  type_q  [DEPTH];
  logic [31:0] instr_q [DEPTH];

  logic             hit;
  logic             drain;
  logic             full;
  logic             bypass;
  logic             push;
  logic [PTR_W-1:0] rel;

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    hit = 1'b0;
    rel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = PTR_W'(i) - head_q;
      if (Ld_valid && ({1'b0, rel} < count_q) && (addr_q[i][31:2] == Ld_addr[31:2]))
        hit = 1'b1;
    end
  end

  assign drain = (count_q != '0) && (!Ld_valid || hit);
  assign full  = (count_q == FULL_CNT);
  assign Stall = hit || (St_valid && full && !drain);

`ifdef STBUF_BYPASS_EN
  assign bypass = (count_q == '0) && St_valid && !Ld_valid;
`else
  assign bypass = 1'b0;
`endif

  assign push  = St_valid && !Stall && !bypass;
  assign Count = count_q;

  always_comb begin
    DM_WE     = 1'b0;
    DM_Addr   = Ld_addr;
    DM_WD     = Ld_wd;
    DM_LStype = Ld_type;
    DM_Instr  = '0;
    if (drain) begin
      DM_WE     = 1'b1;
      DM_Addr   = addr_q[head_q];
      DM_WD     = data_q[head_q];
      DM_LStype = type_q[head_q];
      DM_Instr  = instr_q[head_q];
    end else if (bypass) begin
      DM_WE     = 1'b1;
      DM_Addr   = St_addr;
      DM_WD     = St_data;
      DM_LStype = St_type;
      DM_Instr  = St_instr;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) head_d = head_q + 1'b1;
    if (push)  tail_d = tail_q + 1'b1;
    unique case ({push, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; liveness is defined solely by head/count.
  always_ff @(posedge Clk) begin
    if (push) begin
      addr_q[tail_q]  <= St_addr;
      data_q[tail_q]  <= St_data;
      type_q[tail_q]  <= St_type;
      instr_q[tail_q] <= St_instr;
    end
  end

endmodule

// File: tb/tb_store_buf_m.sv
// Scoreboard bench for store_buf_m: a queue-based reference model predicts stalls, occupancy and memory writes.
module tb_store_buf_m;

  logic        Clk;
  logic        Reset;
  logic        St_valid;
  logic [31:0] St_addr;
  logic [31:0] St_data;
  logic [2:0]  St_type;
  logic [31:0] St_instr;
  logic        Ld_valid;
  logic [31:0] Ld_addr;
  logic [2:0]  Ld_type;
  logic [31:0] Ld_wd;
  logic        Stall;
  logic        DM_WE;
  logic [31:0] DM_Addr;
  logic [31:0] DM_WD;
  logic [2:0]  DM_LStype;
  logic [31:0] DM_Instr;
  logic [2:0]  Count;

  store_buf_m #(.DEPTH(4), .PTR_W(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .St_valid(St_valid), .St_addr(St_addr), .St_data(St_data),
    .St_type(St_type), .St_instr(St_instr),
    .Ld_valid(Ld_valid), .Ld_addr(Ld_addr), .Ld_type(Ld_type), .Ld_wd(Ld_wd),
    .Stall(Stall), .DM_WE(DM_WE), .DM_Addr(DM_Addr), .DM_WD(DM_WD),
    .DM_LStype(DM_LStype), .DM_Instr(DM_Instr), .Count(Count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  typ;
    logic [31:0] instr;
  } ent_t;

  ent_t mdl_q[$];
  ent_t exp_q[$];

  int checks = 0;
  int errors = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every memory write the DUT presents must be the oldest outstanding expected write.
  always @(negedge Clk) begin
    if (DM_WE === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("wr_addr", DM_Addr, e.addr);
        chk("wr_data", DM_WD, e.data);
        chk("wr_type", {29'd0, DM_LStype}, {29'd0, e.typ});
        chk("wr_instr", DM_Instr, e.instr);
      end
    end
  end

  // Called at posedge+1; drives one cycle, checks combinational outputs, advances the model.
  task automatic step(input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic [2:0] st, input logic [31:0] si,
                      input bit lv, input logic [31:0] la, input logic [2:0] lt,
                      input logic [31:0] lw);
    int   cnt;
    bit   hit, drain, stall, byp, we;
    ent_t e;
    St_valid = sv; St_addr = sa; St_data = sd; St_type = st; St_instr = si;
    Ld_valid = lv; Ld_addr = la; Ld_type = lt; Ld_wd = lw;
    #1;
    cnt = mdl_q.size();
    hit = 1'b0;
    foreach (mdl_q[k])
      if (lv && (mdl_q[k].addr[31:2] == la[31:2])) hit = 1'b1;
    drain = (cnt != 0) && (!lv || hit);
    stall = hit || (sv && (cnt == 4) && !drain);
`ifdef STBUF_BYPASS_EN
    byp = (cnt == 0) && sv && !lv;
`else
    byp = 1'b0;
`endif
    we = drain || byp;
    chk("stall", {31'd0, Stall}, {31'd0, stall});
    chk("count", {29'd0, Count}, 32'(cnt));
    chk("dm_we", {31'd0, DM_WE}, {31'd0, we});
    if (!we) begin
      chk("ld_addr", DM_Addr, la);
      chk("ld_type", {29'd0, DM_LStype}, {29'd0, lt});
      chk("ld_wd", DM_WD, lw);
    end
    if (drain) void'(mdl_q.pop_front());
    if (sv && !stall) begin
      e.addr = sa; e.data = sd; e.typ = st; e.instr = si;
      exp_q.push_back(e);
      if (!byp) mdl_q.push_back(e);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 32'h0, 3'd0, 32'h0);
  endtask

  initial begin
    St_valid = 0; St_addr = 0; St_data = 0; St_type = 0; St_instr = 0;
    Ld_valid = 0; Ld_addr = 0; Ld_type = 0; Ld_wd = 0;
    Reset = 1'b0;
    #1 Reset = 1'b1;
    #1;
    chk("rst_count", {29'd0, Count}, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk("rst_we", {31'd0, DM_WE}, 32'd0);
    @(posedge Clk);
    @(posedge Clk);
    #1 Reset = 1'b0;

    // Single store, then drain.
    step(1, 32'h10, 32'h1234_5678, 3'b000, 32'hAC01_0010, 0, 32'h0, 3'd0, 32'h0);
    idle(2);

    // Fill with non-hitting loads held, fifth store stalls, then drain in order.
    for (int i = 0; i < 5; i++)
      step(1, 32'(i * 4), 32'hA000_0000 + 32'(i), 3'b000, 32'h1000 + 32'(i),
           1, 32'h200, 3'd0, 32'hDEAD_0000);
    idle(6);

    // Load hitting a queued word stalls while that entry drains.
    step(1, 32'h20, 32'h5555_AAAA, 3'b000, 32'h2020, 1, 32'h300, 3'd0, 32'h0);
    step(0, 0, 0, 0, 0, 1, 32'h22, 3'b001, 32'h7777_0000);
    step(0, 0, 0, 0, 0, 1, 32'h22, 3'b001, 32'h7777_0000);
    idle(2);

    // Full buffer: stores without loads keep flowing, exercising pointer wrap.
    for (int i = 0; i < 4; i++)
      step(1, 32'h40 + 32'(i * 4), 32'hB000_0000 + 32'(i), 3'b000, 32'h4000 + 32'(i),
           1, 32'h400, 3'd0, 32'h0);
    for (int i = 0; i < 6; i++)
      step(1, 32'h60 + 32'(i * 4), 32'hC000_0000 + 32'(i), 3'b001, 32'h6000 + 32'(i),
           0, 32'h0, 3'd0, 32'h0);
    idle(6);

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++)
      step(1, 32'h80 + 32'(i * 4), 32'hD000_0000 + 32'(i), 3'b000, 32'h8000 + 32'(i),
           1, 32'h500, 3'd0, 32'h0);
    St_valid = 0; Ld_valid = 0;
    #1;
    chk("pre_rst_we", {31'd0, DM_WE}, 32'd1);
    Reset = 1'b1;
    #1;
    chk("async_rst_count", {29'd0, Count}, 32'd0);
    chk("async_rst_we", {31'd0, DM_WE}, 32'd0);
    #1 Reset = 1'b0;
    mdl_q.delete();
    exp_q.delete();
    @(posedge Clk);
    #1;
    idle(3);

    // Byte store into an empty buffer (bypassed when the option is built in).
    step(1, 32'h5, 32'h0000_00AB, 3'b010, 32'h5050, 0, 32'h0, 3'd0, 32'h0);
    idle(2);

    // Randomized traffic over a small address window to provoke hits and full conditions.
    for (int i = 0; i < 400; i++) begin
      bit          sv, lv;
      logic [31:0] sa, la;
      sv = ($urandom_range(0, 9) < 6);
      lv = ($urandom_range(0, 9) < 5);
      sa = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      la = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      step(sv, sa, $urandom, 3'($urandom_range(0, 2)), $urandom,
           lv, la, 3'($urandom_range(0, 5)), $urandom);
    end
    idle(8);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("model_empty", 32'(mdl_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
